// File: rtl/bcd_disp_pkg.sv
// Shared definitions for the BCD display stage: FSM encoding, segment
// constants and the active-low digit table in {g,f,e,d,c,b,a} order.
package bcd_disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  localparam logic [0:9][6:0] SEG_TABLE = {
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  // Double-dabble correction: every BCD nibble of 5 or more gets +3
  function automatic logic [11:0] add3_nibbles(input logic [11:0] bcd);
    logic [11:0] res;
    for (int i = 0; i < 3; i++) begin
      res[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3
                                               : bcd[i*4 +: 4];
    end
    return res;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Nibble to active-low 7-segment code; blank or a non-decimal nibble
// turns all segments off.
module seg7_decoder
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank && (nibble < 4'd10)) begin
      seg = SEG_TABLE[nibble];
    end
  end

endmodule

// File: rtl/bcd_display_8bit.sv
// Samples a signed 8-bit result, converts its magnitude to BCD by
// iterative shift-add-3, and scans the held result onto a 4-digit display.
module bcd_display_8bit
  import bcd_disp_pkg::*;
#(
  parameter int SCAN_DIV = 16
) (
  input  logic        Clk,
  input  logic        Resetn,
  input  logic        Start,
  input  logic [7:0]  Din,
  input  logic        OFin,
  output logic        Busy,
  output logic        Done,
  output logic [11:0] Bcd,
  output logic        Neg,
  output logic        Err,
  output logic [6:0]  Seg,
  output logic [3:0]  Dig
);

  localparam int SCAN_W = SCAN_DIV + 2;

  state_e              state_q, state_d;
  logic [11:0]         work_q, work_d;
  logic [7:0]          mag_q, mag_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                neg_work_q, neg_work_d;
  logic                err_work_q, err_work_d;
  logic [11:0]         bcd_q, bcd_d;
  logic                neg_q, neg_d;
  logic                err_q, err_d;
  logic [SCAN_W-1:0]   scan_q, scan_d;

  logic [11:0]         work_adj;
  logic [19:0]         shifted;

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= IDLE;
      work_q     <= '0;
      mag_q      <= '0;
      cnt_q      <= '0;
      neg_work_q <= 1'b0;
      err_work_q <= 1'b0;
      bcd_q      <= '0;
      neg_q      <= 1'b0;
      err_q      <= 1'b0;
      scan_q     <= '0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      mag_q      <= mag_d;
      cnt_q      <= cnt_d;
      neg_work_q <= neg_work_d;
      err_work_q <= err_work_d;
      bcd_q      <= bcd_d;
      neg_q      <= neg_d;
      err_q      <= err_d;
      scan_q     <= scan_d;
    end
  end

  // Output registers only load on the final shift, so the display never
  // sees partial work values.
  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    mag_d      = mag_q;
    cnt_d      = cnt_q;
    neg_work_d = neg_work_q;
    err_work_d = err_work_q;
    bcd_d      = bcd_q;
    neg_d      = neg_q;
    err_d      = err_q;
    scan_d     = scan_q + 1'b1;
    work_adj   = add3_nibbles(work_q);
    shifted    = {work_adj, mag_q} << 1;

    case (state_q)
      IDLE: begin
        if (Start) begin
          neg_work_d = Din[7];
          err_work_d = OFin;
          mag_d      = Din[7] ? (~Din + 8'd1) : Din;
          work_d     = '0;
          cnt_d      = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        work_d = shifted[19:8];
        mag_d  = shifted[7:0];
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          bcd_d   = shifted[19:8];
          neg_d   = neg_work_q;
          err_d   = err_work_q;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign Busy = (state_q != IDLE);
  assign Done = (state_q == DONE);
  assign Bcd  = bcd_q;
  assign Neg  = neg_q;
  assign Err  = err_q;

  logic [1:0] digit_sel;
  logic [3:0] nibble;
  logic       blank;
  logic [6:0] seg_dec;
  logic [6:0] seg_sign;

  assign digit_sel = scan_q[SCAN_W-1 -: 2];

  // Leading-zero suppression on hundreds and tens; error blanks all numerals
  always_comb begin
    nibble = bcd_q[3:0];
    blank  = err_q;
    case (digit_sel)
      2'd0: nibble = bcd_q[3:0];
      2'd1: begin
        nibble = bcd_q[7:4];
        blank  = err_q || ((bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0));
      end
      2'd2: begin
        nibble = bcd_q[11:8];
        blank  = err_q || (bcd_q[11:8] == 4'd0);
      end
      default: blank = 1'b1;
    endcase
  end

  seg7_decoder u_seg7_decoder (
    .nibble (nibble),
    .blank  (blank),
    .seg    (seg_dec)
  );

  assign seg_sign = err_q ? SEG_E : (neg_q ? SEG_MINUS : SEG_BLANK);
  assign Seg      = (digit_sel == 2'd3) ? seg_sign : seg_dec;
  assign Dig      = ~(4'b0001 << digit_sel);

endmodule

// File: tb/tb_bcd_display_8bit.sv
// Directed bench for bcd_display_8bit with hand-computed BCD results and
// segment patterns, using a short scan period.
module tb_bcd_display_8bit;

  logic        Clk;
  logic        Resetn;
  logic        Start;
  logic [7:0]  Din;
  logic        OFin;
  logic        Busy;
  logic        Done;
  logic [11:0] Bcd;
  logic        Neg;
  logic        Err;
  logic [6:0]  Seg;
  logic [3:0]  Dig;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] BLK = 7'b1111111;

  bcd_display_8bit #(.SCAN_DIV(2)) dut (
    .Clk    (Clk),
    .Resetn (Resetn),
    .Start  (Start),
    .Din    (Din),
    .OFin   (OFin),
    .Busy   (Busy),
    .Done   (Done),
    .Bcd    (Bcd),
    .Neg    (Neg),
    .Err    (Err),
    .Seg    (Seg),
    .Dig    (Dig)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [11:0] obs,
                             input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Waits (bounded) for digit k to be selected, then compares its segments
  task automatic checkDigit(input string tag, input logic [1:0] k,
                            input logic [6:0] exp);
    logic [3:0] want;
    int n;
    want = ~(4'b0001 << k);
    n = 0;
    while (Dig !== want && n < 40) begin
      tick();
      n++;
    end
    if (Dig !== want) checkOutput({tag, "_dig_timeout"}, {8'h0, Dig}, {8'h0, want});
    else checkOutput(tag, {5'h0, Seg}, {5'h0, exp});
  endtask

  // Pulses Start for one edge (E0) and runs to the end of the conversion,
  // checking Done latency and the one-cycle pulse width
  task automatic applyStimulus(input logic [7:0] d, input logic of);
    int n;
    Din = d;
    OFin = of;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    Din = 8'h5A;
    OFin = ~of;
    checkOutput("busy_after_E0", {11'h0, Busy}, 12'h001);
    n = 0;
    while (!Done && n < 20) begin
      tick();
      n++;
    end
    checkOutput("done_latency", n[11:0], 12'd8);
    checkOutput("busy_in_done", {11'h0, Busy}, 12'h001);
    tick();
    checkOutput("done_pulse_end", {11'h0, Done}, 12'h000);
    checkOutput("busy_end", {11'h0, Busy}, 12'h000);
  endtask

  initial begin
    int n;
    int sawDone;
    Resetn = 1'b0;
    Start = 1'b0;
    Din = 8'h00;
    OFin = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    checkOutput("rst_busy", {11'h0, Busy}, 12'h000);
    checkOutput("rst_done", {11'h0, Done}, 12'h000);
    checkOutput("rst_bcd", Bcd, 12'h000);
    checkOutput("rst_neg", {11'h0, Neg}, 12'h000);
    checkOutput("rst_err", {11'h0, Err}, 12'h000);
    checkOutput("rst_dig", {8'h0, Dig}, 12'h00E);
    checkOutput("rst_seg", {5'h0, Seg}, 12'h040);
    Resetn = 1'b1;
    tick();

    applyStimulus(8'd123, 1'b0);
    checkOutput("p123_bcd", Bcd, 12'h123);
    checkOutput("p123_neg", {11'h0, Neg}, 12'h000);
    checkDigit("p123_d2", 2'd2, 7'b1111001);
    checkDigit("p123_d1", 2'd1, 7'b0100100);
    checkDigit("p123_d0", 2'd0, 7'b0110000);
    checkDigit("p123_d3", 2'd3, BLK);

    applyStimulus(8'hFF, 1'b0);
    checkOutput("nFF_bcd", Bcd, 12'h001);
    checkOutput("nFF_neg", {11'h0, Neg}, 12'h001);
    checkDigit("nFF_d3", 2'd3, 7'b0111111);
    checkDigit("nFF_d2", 2'd2, BLK);
    checkDigit("nFF_d1", 2'd1, BLK);
    checkDigit("nFF_d0", 2'd0, 7'b1111001);

    applyStimulus(8'h80, 1'b0);
    checkOutput("n80_bcd", Bcd, 12'h128);
    checkOutput("n80_neg", {11'h0, Neg}, 12'h001);
    checkDigit("n80_d1", 2'd1, 7'b0100100);
    checkDigit("n80_d0", 2'd0, 7'b0000000);

    applyStimulus(8'h7F, 1'b0);
    checkOutput("p7F_bcd", Bcd, 12'h127);
    checkOutput("p7F_neg", {11'h0, Neg}, 12'h000);

    applyStimulus(8'h00, 1'b0);
    checkOutput("z_bcd", Bcd, 12'h000);
    checkDigit("z_d3", 2'd3, BLK);
    checkDigit("z_d2", 2'd2, BLK);
    checkDigit("z_d1", 2'd1, BLK);
    checkDigit("z_d0", 2'd0, 7'b1000000);

    applyStimulus(8'h05, 1'b1);
    checkOutput("of_err", {11'h0, Err}, 12'h001);
    checkOutput("of_bcd", Bcd, 12'h005);
    checkDigit("of_d3", 2'd3, 7'b0000110);
    checkDigit("of_d2", 2'd2, BLK);
    checkDigit("of_d1", 2'd1, BLK);
    checkDigit("of_d0", 2'd0, BLK);

    applyStimulus(8'h05, 1'b0);
    checkOutput("ofclr_err", {11'h0, Err}, 12'h000);
    checkDigit("ofclr_d0", 2'd0, 7'b0010010);
    checkDigit("ofclr_d3", 2'd3, BLK);

    // Second Start around E3 with a different value must be ignored
    Din = 8'd45;
    OFin = 1'b0;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    tick();
    Din = 8'd99;
    OFin = 1'b1;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    n = 3;
    while (!Done && n < 20) begin
      tick();
      n++;
    end
    checkOutput("restart_latency", n[11:0], 12'd8);
    checkOutput("restart_bcd", Bcd, 12'h045);
    checkOutput("restart_err", {11'h0, Err}, 12'h000);
    tick();
    tick();

    // Reset asserted at E5 of a conversion
    Din = 8'd77;
    OFin = 1'b1;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (5) tick();
    Resetn = 1'b0;
    #1;
    checkOutput("mid_rst_busy", {11'h0, Busy}, 12'h000);
    checkOutput("mid_rst_bcd", Bcd, 12'h000);
    checkOutput("mid_rst_err", {11'h0, Err}, 12'h000);
    checkOutput("mid_rst_dig", {8'h0, Dig}, 12'h00E);
    checkOutput("mid_rst_seg", {5'h0, Seg}, 12'h040);
    tick();
    Resetn = 1'b1;
    sawDone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (Done) sawDone = 1;
    end
    checkOutput("mid_rst_no_done", sawDone[11:0], 12'd0);
    checkOutput("mid_rst_busy_after", {11'h0, Busy}, 12'h000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
